// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the execute stage: iterative shift-add multiply and restoring divide,
// one bit per cycle, plus direct MTHI/MTLO writes.
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    // Upper half: accumulator / partial remainder. Lower half: multiplier / dividend->quotient.
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_mul_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               res_sign;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   rem_neg;
    logic [WIDTH-1:0]   quo_neg;

    always_comb begin
        is_signed = ~op_i[0];
        a_mag     = (is_signed && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
        b_mag     = (is_signed && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;
        res_sign  = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod_neg  = '0 - prod_q;
        rem_neg   = '0 - prod_q[2*WIDTH-1:WIDTH];
        quo_neg   = '0 - prod_q[WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            is_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        case (op_i)
                            3'b000, 3'b001: begin
                                state_q  <= StMul;
                                cnt_q    <= '0;
                                prod_q   <= {{WIDTH{1'b0}}, b_mag};
                                opnd_q   <= a_mag;
                                is_mul_q <= 1'b1;
                                neg_lo_q <= res_sign;
                                neg_hi_q <= 1'b0;
                                busy_q   <= 1'b1;
                            end
                            3'b010, 3'b011: begin
                                state_q  <= StDiv;
                                cnt_q    <= '0;
                                prod_q   <= {{WIDTH{1'b0}}, a_mag};
                                opnd_q   <= b_mag;
                                is_mul_q <= 1'b0;
                                // Divide by zero leaves the all-ones quotient unnegated.
                                neg_lo_q <= res_sign & (b_i != '0);
                                neg_hi_q <= is_signed & a_i[WIDTH-1];
                                busy_q   <= 1'b1;
                            end
                            3'b100:  hi_q <= a_i;
                            3'b101:  lo_q <= a_i;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) state_q <= StFix;
                end
                StDiv: begin
                    if (!div_diff[WIDTH]) begin
                        prod_q <= {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    end else begin
                        prod_q <= {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) state_q <= StFix;
                end
                StFix: begin
                    if (is_mul_q) begin
                        {hi_q, lo_q} <= neg_lo_q ? prod_neg : prod_q;
                    end else begin
                        hi_q <= neg_hi_q ? rem_neg : prod_q[2*WIDTH-1:WIDTH];
                        lo_q <= neg_lo_q ? quo_neg : prod_q[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: table of mul/div vectors plus hand sequences for
// MTHI/MTLO, start-while-busy and mid-operation reset.
module tb_hilo_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .hi_o    (hi),
        .lo_o    (lo),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one mul/div and follows it to completion; intr_cyc > 0 pulses a second Start
    // (op intr_op) on that busy cycle, which must be ignored.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int intr_cyc, input logic [2:0] intr_op);
        int n;
        bit hold_ok;
        bit done_quiet;
        n = 0;
        hold_ok = 1'b1;
        done_quiet = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        while (busy && n < 100) begin
            n++;
            if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            if (done !== 1'b0) done_quiet = 1'b0;
            if (n == intr_cyc) begin
                start = 1'b1; op = intr_op; a = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " busy_cycles"}, 64'(n), 64'd33);
        check({name, " hold"}, {63'd0, hold_ok}, 64'd1);
        check({name, " done_quiet"}, {63'd0, done_quiet}, 64'd1);
        check({name, " done"}, {63'd0, done}, 64'd1);
        check({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({name, " lo"}, {32'd0, lo}, {32'd0, elo});
        m_hi = ehi;
        m_lo = elo;
        @(negedge clk);
        check({name, " done_drop"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'd100,       32'd101,       32'h0000_0000, 32'h0000_2774};
        vecs[1]  = '{3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB};
        vecs[3]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{3'b011, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[8]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[10] = '{3'b011, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF};
        vecs[11] = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 0, 3'b000);
        end

        // Start during a DIV must not disturb it, whether MTHI or another mul/div.
        run_op("div_mthi_intr", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               10, 3'b100);
        run_op("div_mult_intr", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 5, 3'b000);

        // MTHI then MTLO on consecutive edges, then a reserved op.
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi hi", {32'd0, hi}, 64'hDEAD_BEEF);
        check("mthi lo", {32'd0, lo}, {32'd0, m_lo});
        check("mthi busy", {63'd0, busy}, 64'd0);
        op = 3'b101; a = 32'h0BAD_F00D;
        @(negedge clk);
        check("mtlo lo", {32'd0, lo}, 64'h0BAD_F00D);
        check("mtlo hi", {32'd0, hi}, 64'hDEAD_BEEF);
        check("mtlo busy", {63'd0, busy}, 64'd0);
        check("mtlo done", {63'd0, done}, 64'd0);
        op = 3'b110; a = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        check("rsvd hi", {32'd0, hi}, 64'hDEAD_BEEF);
        check("rsvd lo", {32'd0, lo}, 64'h0BAD_F00D);
        check("rsvd busy", {63'd0, busy}, 64'd0);
        m_hi = 32'hDEAD_BEEF;
        m_lo = 32'h0BAD_F00D;

        // Reset in the middle of a MULT discards it.
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset busy", {63'd0, busy}, 64'd1);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset hi", {32'd0, hi}, 64'd0);
        check("midreset lo", {32'd0, lo}, 64'd0);
        begin
            bit quiet;
            quiet = 1'b1;
            for (int i = 0; i < 30; i++) begin
                if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
                @(negedge clk);
            end
            check("midreset no_done", {63'd0, quiet}, 64'd1);
        end
        m_hi = '0;
        m_lo = '0;
        run_op("post_reset mult", 3'b000, 32'd5, 32'd6, 32'd0, 32'd30, 0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair for the execute stage of the pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the ALU control path and runs a 32-iteration shift-add or restoring-divide loop. It holds Busy so the hazard unit stalls dependent instructions, and presents HI/LO to the MFHI/MFLO forwarding path.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk.
- Start  in  1  request strobe, sampled each rising edge.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored).
- A  in  WIDTH  rs operand: multiplicand or dividend; MTHI/MTLO source.
- B  in  WIDTH  rt operand: multiplier or divisor.
- HI  out  WIDTH  HI register: product upper word or remainder.
- LO  out  WIDTH  LO register: product lower word or quotient.
- Busy  out  1  registered; high while a mul/div is in flight.
- Done  out  1  registered one-cycle pulse when HI/LO receive a mul/div result.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with Start=1:
  - MULT/MULTU: latch |A|, |B| and result sign; clear the 2*WIDTH accumulator and the iteration counter; go to MUL. Signed ops use magnitudes; unsigned ops use raw values.
  - DIV/DIVU: latch magnitudes and the quotient sign (sign(A)^sign(B)) and remainder sign (sign(A)); go to DIV.
  - MTHI: HI<=A. MTLO: LO<=A. Both stay in IDLE, with no Busy and no Done.
  - Reserved Op: no effect.
- MUL: one shift-add step per cycle (LSB of the multiplier selects the add). Go to FIX after WIDTH steps.
- DIV: one restoring step per cycle (shift remainder, trial subtract, quotient bit = no-borrow). Go to FIX after WIDTH steps.
- FIX: apply two's-complement negation per the latched signs (signed ops only). Write HI/LO, pulse Done, return to IDLE.
- Divide by zero: no trap. Full 33-cycle latency is kept. Result is HI=A (unmodified), LO=all ones, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of the magnitude path.
- Start while Busy=1: ignored regardless of Op, and HI/LO are untouched. The hazard unit must hold the instruction.
- HI/LO keep their old values during MUL/DIV and change only in FIX, on MTHI/MTLO, or on Reset.
- Operands A/B may change after the accept edge without affecting the result.

## Timing
- Reset (any state, including mid-operation): on the next edge go to IDLE with HI=0, LO=0, Busy=0, Done=0. Any in-flight operation is discarded.
- Accept edge E0 (Start=1, Busy=0, mul/div Op): Busy=1 after E0.
- Iterations run on edges E1..E32 and FIX executes at E33.
- After E33: HI/LO hold the result, Busy=0, Done=1 for exactly one cycle (cleared after E34).
- Busy is therefore high for 33 cycles.
- A new Start may be accepted at E33 only if Busy=0 is already visible, which it is not. The earliest next accept is E34, the same edge on which Done drops.
- MTHI/MTLO: 1-cycle latency; the new value is visible after the accept edge.

## Test plan
- Reset, then MULT A=100, B=101 at E0 -> Busy high for 33 cycles; after E33 Done=1, HI=0x00000000, LO=0x00002774.
- MULT A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064, Done after 33 cycles.
- During a DIV in flight, pulse Start with MTHI A=0x12345678 at cycle 10 -> ignored. Final HI/LO equal the DIV result and Done appears at the normal cycle.
- MTHI A=0xDEADBEEF then MTLO A=0x0BADF00D on consecutive cycles -> HI/LO update one cycle after each strobe, with Busy=0 and Done=0 throughout.
- Start MULT 5*6, assert Reset at cycle 15 -> after that edge Busy=0, HI=LO=0, and Done never pulses. A fresh MULT 5*6 then gives LO=30.
